sha256_frame_padder: RTL and testbench

SHA256_FRAME_PADDER -- requirements
Module: sha256_frame_padder

---
 rtl/sha256_frame_padder_pkg.sv | 16 +
 rtl/sha256_word_packer.sv | 49 ++++
 rtl/sha256_frame_padder.sv | 137 +++++++++++++
 tb/tb_sha256_frame_padder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_frame_padder_pkg.sv
// sha256_frame_padder_pkg: shared FSM state, padding constants and error bit positions
// Contents: state_t (IDLE/HDR/DATA/PAD/BITLEN), PAD_BYTE, PAD_THRESH, LEN_BITS_W,
// ERR_TIMEOUT/ERR_OVERFLOW bit indices, total_words() block-count helper.
package sha256_frame_padder_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, PAD, BITLEN} state_t;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int PAD_THRESH = 56;
  localparam int LEN_BITS_W = 64;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERFLOW = 1;
  // Words in the whole padded message: 16 per block, one extra block when the
  // 0x80 marker plus the 8-byte length no longer fit behind the tail bytes.
  function automatic logic [31:0] total_words(input logic [31:0] len);
    return {{2'b0, len[31:6]} + ((len[5:0] >= 6'(PAD_THRESH)) ? 28'd2 : 28'd1), 4'b0};
  endfunction
endpackage

// File: rtl/sha256_word_packer.sv
// sha256_word_packer: byte-to-word shift register plus one-word holding register
// Ports: clk/rst; clr discards partial bytes and the held word; byte_vld/byte_in feed
// message bytes; ld/ld_word load a generated word; ack = held word accepted;
// word_out/word_valid = held word; part_word = pending bytes left-justified;
// nbytes = pending byte count; full = this byte completes a word.
module sha256_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  input  logic        ld,
  input  logic [31:0] ld_word,
  input  logic        ack,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic [31:0] part_word,
  output logic [1:0]  nbytes,
  output logic        full
);
  logic [23:0] sr_q, sr_d;
  logic [1:0]  n_q, n_d;
  logic [31:0] hold_q, hold_d;
  logic        vld_q, vld_d;
  always_comb begin
    full      = byte_vld && n_q == 2'd3;
    sr_d      = clr ? 24'b0 : byte_vld ? {sr_q[15:0], byte_in} : sr_q;
    n_d       = clr ? 2'd0 : byte_vld ? n_q + 2'd1 : n_q;
    hold_d    = full ? {sr_q, byte_in} : ld ? ld_word : hold_q;
    vld_d     = clr ? 1'b0 : (full || ld) ? 1'b1 : ack ? 1'b0 : vld_q;
    part_word = n_q == 2'd0 ? 32'b0 : {sr_q, 8'b0} << {2'd3 - n_q, 3'b0};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      n_q    <= '0;
      hold_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      n_q    <= n_d;
      hold_q <= hold_d;
      vld_q  <= vld_d;
    end
  end
  assign word_out   = hold_q;
  assign word_valid = vld_q;
  assign nbytes     = n_q;
endmodule

// File: rtl/sha256_frame_padder.sv
// sha256_frame_padder: turns length-prefixed UART frames into SHA-256 padded 32-bit words
// Ports: clk/rst; rx_dv_in/rx_byte_in = received byte strobe; word_ready_in = core accept;
// word_out/word_valid_out/word_idx_out/block_last_out = word stream; abort_out = frame
// discarded pulse; err_out = sticky {overflow, timeout}; busy_out = not IDLE.
module sha256_frame_padder
  import sha256_frame_padder_pkg::*;
#(
  parameter int LEN_BYTES   = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv_in,
  input  logic [7:0]  rx_byte_in,
  input  logic        word_ready_in,
  output logic [31:0] word_out,
  output logic        word_valid_out,
  output logic [3:0]  word_idx_out,
  output logic        block_last_out,
  output logic        abort_out,
  output logic [1:0]  err_out,
  output logic        busy_out
);
  state_t state_q, state_d;
  logic [31:0] len_q, len_d, msg_q, msg_d, idle_q, idle_d, acc_q, acc_d;
  logic [2:0]  hdr_q, hdr_d;
  logic [1:0]  err_q, err_d;
  logic        abort_q, abort_d, first_q, first_d;
  logic        clr, ld, full, hold_vld, accept, room, in_frame, timeout, overflow;
  logic [31:0] ld_word, hold_word, part_word, pad_word, len_nxt, total, gen;
  logic [1:0]  nbytes;
  logic [LEN_BITS_W-1:0] len_bits;
  sha256_word_packer u_packer (
    .clk(clk), .rst(rst), .clr(clr), .byte_vld(state_q == DATA && rx_dv_in),
    .byte_in(rx_byte_in), .ld(ld), .ld_word(ld_word), .ack(word_ready_in),
    .word_out(hold_word), .word_valid(hold_vld), .part_word(part_word),
    .nbytes(nbytes), .full(full)
  );
  always_comb begin
    total    = total_words(len_q);
    gen      = acc_q + 32'(hold_vld);
    accept   = hold_vld && word_ready_in;
    room     = !hold_vld || word_ready_in;
    len_bits = LEN_BITS_W'(len_q) << 3;
    len_nxt  = {len_q[23:0], rx_byte_in};
    pad_word = part_word | (32'(PAD_BYTE) << (5'd24 - {nbytes, 3'b0}));
    in_frame = state_q == HDR || state_q == DATA;
    timeout  = in_frame && !rx_dv_in && idle_q + 32'd1 == 32'(TIMEOUT_CYC);
    overflow = full && hold_vld && !word_ready_in;
    state_d  = state_q;
    len_d    = len_q;
    hdr_d    = hdr_q;
    msg_d    = msg_q;
    idle_d   = (rx_dv_in || !in_frame) ? 32'd0 : idle_q + 32'd1;
    acc_d    = acc_q + 32'(accept);
    err_d    = err_q;
    abort_d  = 1'b0;
    first_d  = first_q;
    clr      = 1'b0;
    ld       = 1'b0;
    ld_word  = 32'b0;
    case (state_q)
      IDLE: if (rx_dv_in) begin
        len_d   = {24'b0, rx_byte_in};
        hdr_d   = 3'd1;
        msg_d   = '0;
        acc_d   = '0;
        err_d   = '0;
        first_d = 1'b1;
        clr     = 1'b1;
        state_d = LEN_BYTES == 1 ? (rx_byte_in == 8'd0 ? PAD : DATA) : HDR;
      end
      HDR: if (rx_dv_in) begin
        len_d = len_nxt;
        hdr_d = hdr_q + 3'd1;
        if (32'(hdr_q) == LEN_BYTES - 1) state_d = len_nxt == 32'd0 ? PAD : DATA;
      end
      DATA: if (rx_dv_in) begin
        msg_d = msg_q + 32'd1;
        if (msg_d == len_q) state_d = PAD;
      end
      // Only the first padding word carries the tail bytes and the 0x80 marker.
      PAD: if (room) begin
        ld      = 1'b1;
        ld_word = first_q ? pad_word : 32'b0;
        first_d = 1'b0;
        if (gen == total - 32'd3) state_d = BITLEN;
      end
      BITLEN: begin
        if (room && gen != total) begin
          ld      = 1'b1;
          ld_word = gen == total - 32'd2 ? len_bits[63:32] : len_bits[31:0];
        end
        if (accept && acc_q == total - 32'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout || overflow) begin
      state_d = IDLE;
      err_d[ERR_TIMEOUT]  = err_q[ERR_TIMEOUT] | timeout;
      err_d[ERR_OVERFLOW] = err_q[ERR_OVERFLOW] | overflow;
      abort_d = 1'b1;
      clr     = 1'b1;
      acc_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      hdr_q   <= '0;
      msg_q   <= '0;
      idle_q  <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      msg_q   <= msg_d;
      idle_q  <= idle_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      first_q <= first_d;
    end
  end
  assign word_out       = hold_word;
  assign word_valid_out = hold_vld;
  assign word_idx_out   = acc_q[3:0];
  assign block_last_out = hold_vld && acc_q >= total - 32'd16;
  assign abort_out      = abort_q;
  assign err_out        = err_q;
  assign busy_out       = state_q != IDLE;
endmodule

// File: tb/tb_sha256_frame_padder.sv
// tb_sha256_frame_padder: scoreboard bench against a byte-level FIPS 180-4 padding model
module tb_sha256_frame_padder;
  localparam int TO = 300;
  logic        clk = 1'b0, rst = 1'b1, rx_dv_in = 1'b0, word_ready_in = 1'b0;
  logic [7:0]  rx_byte_in = 8'h00;
  logic [31:0] word_out;
  logic        word_valid_out, block_last_out, abort_out, busy_out;
  logic [3:0]  word_idx_out;
  logic [1:0]  err_out;
  int total = 0, bad = 0, abort_cnt = 0, ready_mode = 1, a0;
  typedef struct {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        last;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] m[$];

  always #5 clk = ~clk;

  sha256_frame_padder #(.LEN_BYTES(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_dv_in(rx_dv_in), .rx_byte_in(rx_byte_in),
    .word_ready_in(word_ready_in), .word_out(word_out), .word_valid_out(word_valid_out),
    .word_idx_out(word_idx_out), .block_last_out(block_last_out), .abort_out(abort_out),
    .err_out(err_out), .busy_out(busy_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Ready driver: random back-pressure never holds ready low more than 2 cycles.
  initial begin
    int low;
    low = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        word_ready_in = (low >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        low = word_ready_in ? 0 : low + 1;
      end else word_ready_in = (ready_mode == 1);
    end
  end

  always @(negedge clk) begin
    if (abort_out) abort_cnt++;
    if (!rst && word_valid_out && word_ready_in) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h expected none", word_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word", word_out, mon_e.w);
        chk("idx", 32'(word_idx_out), 32'(mon_e.idx));
        chk("last", 32'(block_last_out), 32'(mon_e.last));
      end
    end
  end

  task automatic push_model(input logic [7:0] msg[$]);
    logic [7:0]  b[$];
    logic [63:0] bits;
    int nw;
    exp_t e;
    b = msg;
    bits = 64'(msg.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int i = 7; i >= 0; i--) b.push_back(bits[8*i +: 8]);
    nw = b.size() / 4;
    for (int w = 0; w < nw; w++) begin
      e.w = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
      e.idx = 4'(w % 16);
      e.last = (w >= nw - 16);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv_in = 1'b1;
    rx_byte_in = b;
    @(negedge clk);
    rx_dv_in = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_hdr(input int len);
    send_byte(len[15:8]);
    gap();
    send_byte(len[7:0]);
    gap();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy_out || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done", 32'(n < 3000), 32'd1);
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] q[$]);
    push_model(q);
    send_hdr(q.size());
    foreach (q[i]) begin
      send_byte(q[i]);
      gap();
    end
    wait_done();
    chk("err_clean", 32'(err_out), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_out && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(word_valid_out), 32'd0);
    chk("rst_word", word_out, 32'd0);
    chk("rst_idx", 32'(word_idx_out), 32'd0);
    chk("rst_last", 32'(block_last_out), 32'd0);
    chk("rst_abort", 32'(abort_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    m = {8'h61, 8'h62, 8'h63};
    send_frame(m);
    m.delete();
    send_frame(m);
    for (int i = 0; i < 56; i++) m.push_back(8'(i));
    push_model(m);
    ready_mode = 2;
    send_hdr(56);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("pre_latency_valid", 32'(word_valid_out), 32'd0);
      send_byte(m[i]);
    end
    chk("latency_valid", 32'(word_valid_out), 32'd1);
    chk("latency_word", word_out, 32'h00010203);
    ready_mode = 0;
    for (int i = 4; i < 56; i++) begin
      send_byte(m[i]);
      gap();
    end
    wait_done();
    for (int f = 0; f < 6; f++) begin
      int len;
      len = (f == 0) ? 55 : (f == 1) ? 64 : $urandom_range(0, 150);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send_frame(m);
    end
    ready_mode = 1;
    a0 = abort_cnt;
    send_hdr(10);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    wait_idle(TO + 50);
    chk("to_busy", 32'(busy_out), 32'd0);
    chk("to_err", 32'(err_out), 32'd1);
    chk("to_aborts", 32'(abort_cnt - a0), 32'd1);
    m = {8'h61, 8'h62, 8'h63};
    send_frame(m);
    ready_mode = 2;
    a0 = abort_cnt;
    send_hdr(20);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'($urandom));
      gap();
    end
    wait_idle(50);
    chk("ovf_err", 32'(err_out), 32'd2);
    chk("ovf_aborts", 32'(abort_cnt - a0), 32'd1);
    chk("ovf_valid", 32'(word_valid_out), 32'd0);
    chk("ovf_busy", 32'(busy_out), 32'd0);
    a0 = abort_cnt;
    send_hdr(20);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'($urandom));
      gap();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(word_valid_out), 32'd0);
    chk("mid_rst_word", word_out, 32'd0);
    chk("mid_rst_busy", 32'(busy_out), 32'd0);
    chk("mid_rst_err", 32'(err_out), 32'd0);
    chk("mid_rst_idx", 32'(word_idx_out), 32'd0);
    chk("mid_rst_aborts", 32'(abort_cnt - a0), 32'd0);
    rst = 1'b0;
    ready_mode = 1;
    @(negedge clk);
    m = {8'h61, 8'h62, 8'h63};
    send_frame(m);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
